// File: rtl/cv32e40p_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_pkg (slice)
// Shared constants for the cv32e40p core and its platform interrupt source.
//   - CSR_*IX_BIT  : bit positions of the standard machine interrupts in mip/mie
//   - IRQ_MASK     : interrupt lines the core actually implements
//   - IRQ_SRC_*    : register word offsets and defaults of cv32e40p_irq_source
// ---------------------------------------------------------------------------
package cv32e40p_pkg;

    // Standard machine interrupt positions
    localparam int CSR_MSIX_BIT = 3;
    localparam int CSR_MTIX_BIT = 7;
    localparam int CSR_MEIX_BIT = 11;

    // Implemented interrupt lines: fast interrupts 31:16 plus MEI/MTI/MSI
    localparam logic [31:0] IRQ_MASK = 32'hFFFF_0888;

    // Interrupt source: lines that are edge-captured and cleared by acknowledge
    localparam logic [31:0] IRQ_SRC_EDGE_MASK = 32'hFFFF_0000;

    // Interrupt source: register word offsets (reg_addr_i[4:2])
    localparam logic [2:0] IRQ_SRC_PEND     = 3'd0;
    localparam logic [2:0] IRQ_SRC_SET      = 3'd1;
    localparam logic [2:0] IRQ_SRC_CLR      = 3'd2;
    localparam logic [2:0] IRQ_SRC_MTIME    = 3'd3;
    localparam logic [2:0] IRQ_SRC_MTIMECMP = 3'd4;
    localparam logic [2:0] IRQ_SRC_CTRL     = 3'd5;

    // Compare value after reset: never matches a running counter until wrap
    localparam logic [31:0] IRQ_SRC_MTIMECMP_RST = 32'hFFFF_FFFF;

    // One-hot decode of a 5-bit interrupt id
    function automatic logic [31:0] irq_src_onehot(input logic [4:0] id);
        irq_src_onehot = 32'd1 << id;
    endfunction

endpackage

// File: rtl/cv32e40p_irq_timer.sv
// ---------------------------------------------------------------------------
// cv32e40p_irq_timer
// Free-running machine timer with compare, producing a registered MTI level.
//   clk, rst_n       : clock, synchronous active-low reset
//   i_en             : counter enable (CTRL bit 0)
//   i_mtime_we       : load mtime from i_wdata (wins over the increment)
//   i_mtimecmp_we    : load mtimecmp from i_wdata
//   i_wdata          : register write data
//   o_mtime          : current counter value
//   o_mtimecmp       : current compare value
//   o_mti            : registered (i_en && mtime >= mtimecmp)
// ---------------------------------------------------------------------------
module cv32e40p_irq_timer
    import cv32e40p_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_mtime_we,
    input  logic        i_mtimecmp_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_mtime,
    output logic [31:0] o_mtimecmp,
    output logic        o_mti
);

    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        r_mti;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= IRQ_SRC_MTIMECMP_RST;
            r_mti      <= 1'b0;
        end else begin
            // Software load has priority; otherwise count, wrapping naturally
            if (i_mtime_we) begin
                r_mtime <= i_wdata;
            end else if (i_en) begin
                r_mtime <= r_mtime + 32'd1;
            end

            if (i_mtimecmp_we) begin
                r_mtimecmp <= i_wdata;
            end

            // Compare uses the current register values, so a write shows up
            // in MTI one cycle after it lands
            r_mti <= i_en && (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_mti      = r_mti;

endmodule

// File: rtl/cv32e40p_irq_source.sv
// ---------------------------------------------------------------------------
// cv32e40p_irq_source
// Platform-side interrupt generator driving the core's level-sensitive irq
// lines. Fast interrupts are rising-edge captured into pending flags and
// cleared by the core's acknowledge; MEI is a registered level of event_i[11];
// MSI is a software flag; MTI comes from the internal timer.
//   clk, rst_n        : clock, synchronous active-low reset
//   event_i[31:0]     : platform events, synchronous to clk
//   irq_o[31:0]       : level interrupt requests (registered state only)
//   irq_ack_i         : single-cycle acknowledge from the core
//   irq_id_i[4:0]     : id being acknowledged
//   reg_req_i         : register access request (always granted)
//   reg_we_i          : 1=write, 0=read
//   reg_addr_i[4:0]   : byte address, word select in [4:2]
//   reg_wdata_i[31:0] : write data
//   reg_gnt_o         : grant (= reg_req_i)
//   reg_rvalid_o      : response valid, one cycle after each access
//   reg_rdata_o[31:0] : read data (0 for writes)
// Register map: 0 PEND(R) 1 SET(W1S) 2 CLR(W1C) 3 MTIME 4 MTIMECMP 5 CTRL
// ---------------------------------------------------------------------------
module cv32e40p_irq_source
    import cv32e40p_pkg::*;
#(
    parameter int          NUM_INTERRUPTS = 32,
    parameter logic [31:0] IRQ_MASK       = cv32e40p_pkg::IRQ_MASK,
    parameter logic [31:0] EDGE_MASK      = cv32e40p_pkg::IRQ_SRC_EDGE_MASK
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_INTERRUPTS-1:0] event_i,
    output logic [NUM_INTERRUPTS-1:0] irq_o,
    input  logic                      irq_ack_i,
    input  logic [4:0]                irq_id_i,
    input  logic                      reg_req_i,
    input  logic                      reg_we_i,
    input  logic [4:0]                reg_addr_i,
    input  logic [31:0]               reg_wdata_i,
    output logic                      reg_gnt_o,
    output logic                      reg_rvalid_o,
    output logic [31:0]               reg_rdata_o
);

    localparam logic [31:0] EDGE_BITS = EDGE_MASK & IRQ_MASK;

    // State
    logic [NUM_INTERRUPTS-1:0] r_event_q;
    logic [NUM_INTERRUPTS-1:0] r_pending;
    logic                      r_msip;
    logic                      r_mei_q;
    logic                      r_ctrl_en;
    logic                      r_rvalid;
    logic [31:0]               r_rdata;

    // Decode
    logic [2:0]                w_sel;
    logic                      w_wr;
    logic                      w_rd;
    logic [31:0]               w_set_wr;
    logic [31:0]               w_clr_wr;
    logic [NUM_INTERRUPTS-1:0] w_rise;
    logic [NUM_INTERRUPTS-1:0] w_ack_clr;
    logic [NUM_INTERRUPTS-1:0] w_pend_set;
    logic [NUM_INTERRUPTS-1:0] w_pend_clr;
    logic [NUM_INTERRUPTS-1:0] w_pend_nxt;
    logic [NUM_INTERRUPTS-1:0] w_irq_raw;
    logic [31:0]               w_rdata_nxt;
    logic [31:0]               w_mtime;
    logic [31:0]               w_mtimecmp;
    logic                      w_mti;
    logic                      w_unused_addr;

    assign w_sel = reg_addr_i[4:2];
    assign w_wr  = reg_req_i &  reg_we_i;
    assign w_rd  = reg_req_i & ~reg_we_i;

    // Byte offset within the word carries no meaning
    assign w_unused_addr = ^reg_addr_i[1:0];

    assign w_set_wr = (w_wr && (w_sel == IRQ_SRC_SET)) ? reg_wdata_i : '0;
    assign w_clr_wr = (w_wr && (w_sel == IRQ_SRC_CLR)) ? reg_wdata_i : '0;

    // Edge capture against last cycle's event sample
    assign w_rise = event_i & ~r_event_q & EDGE_BITS;

    // Ack only touches edge-captured lines; other ids fall outside EDGE_BITS
    assign w_ack_clr = irq_ack_i ? (irq_src_onehot(irq_id_i) & EDGE_BITS) : '0;

    assign w_pend_set = w_rise | (w_set_wr & EDGE_BITS);
    assign w_pend_clr = w_ack_clr | (w_clr_wr & EDGE_BITS);

    // Set is OR'd after the clear so a coinciding set always survives
    assign w_pend_nxt = (r_pending & ~w_pend_clr) | w_pend_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_event_q <= '0;
            r_pending <= '0;
            r_msip    <= 1'b0;
            r_mei_q   <= 1'b0;
            r_ctrl_en <= 1'b0;
        end else begin
            r_event_q <= event_i;
            r_pending <= w_pend_nxt;
            r_mei_q   <= event_i[CSR_MEIX_BIT];

            // SET and CLR share one port, so they never coincide
            if (w_set_wr[CSR_MSIX_BIT]) begin
                r_msip <= 1'b1;
            end else if (w_clr_wr[CSR_MSIX_BIT]) begin
                r_msip <= 1'b0;
            end

            if (w_wr && (w_sel == IRQ_SRC_CTRL)) begin
                r_ctrl_en <= reg_wdata_i[0];
            end
        end
    end

    cv32e40p_irq_timer u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (r_ctrl_en),
        .i_mtime_we    (w_wr && (w_sel == IRQ_SRC_MTIME)),
        .i_mtimecmp_we (w_wr && (w_sel == IRQ_SRC_MTIMECMP)),
        .i_wdata       (reg_wdata_i),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_mti         (w_mti)
    );

    // irq_o is a pure function of registers: no input reaches it in-cycle
    always_comb begin
        w_irq_raw               = r_pending;
        w_irq_raw[CSR_MSIX_BIT] = r_pending[CSR_MSIX_BIT] | r_msip;
        w_irq_raw[CSR_MTIX_BIT] = r_pending[CSR_MTIX_BIT] | w_mti;
        w_irq_raw[CSR_MEIX_BIT] = r_pending[CSR_MEIX_BIT] | r_mei_q;
    end

    assign irq_o = w_irq_raw & IRQ_MASK;

    // Read mux; SET/CLR and unmapped words read 0
    always_comb begin
        w_rdata_nxt = '0;
        case (w_sel)
            IRQ_SRC_PEND:     w_rdata_nxt = irq_o;
            IRQ_SRC_MTIME:    w_rdata_nxt = w_mtime;
            IRQ_SRC_MTIMECMP: w_rdata_nxt = w_mtimecmp;
            IRQ_SRC_CTRL:     w_rdata_nxt = {31'd0, r_ctrl_en};
            default:          w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= reg_req_i;
            r_rdata  <= w_rd ? w_rdata_nxt : '0;
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = r_rvalid;
    assign reg_rdata_o  = r_rdata;

endmodule

// File: tb/tb_cv32e40p_irq_source.sv
module tb_cv32e40p_irq_source;

    localparam logic [4:0] A_PEND     = 5'd0;
    localparam logic [4:0] A_SET      = 5'd4;
    localparam logic [4:0] A_CLR      = 5'd8;
    localparam logic [4:0] A_MTIME    = 5'd12;
    localparam logic [4:0] A_MTIMECMP = 5'd16;
    localparam logic [4:0] A_CTRL     = 5'd20;
    localparam logic [4:0] A_RSV6     = 5'd24;
    localparam logic [4:0] A_RSV7     = 5'd28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] event_i;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_gnt_o;
    logic        reg_rvalid_o;
    logic [31:0] reg_rdata_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rd;

    cv32e40p_irq_source dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_i      (event_i),
        .irq_o        (irq_o),
        .irq_ack_i    (irq_ack_i),
        .irq_id_i     (irq_id_i),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_gnt_o    (reg_gnt_o),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        reg_req_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = a;
        reg_wdata_i = d;
        tick();
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        reg_req_i  = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = a;
        tick();
        reg_req_i  = 1'b0;
        d          = reg_rdata_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL reset_irq: got %h want %h", irq_o, 32'h0); end
        n_vec++; if (reg_rvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", reg_rvalid_o); end
        n_vec++; if (reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", reg_rdata_o); end
        rst_n = 1'b1;
        reg_read(A_MTIMECMP, rd);
        n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_mtimecmp: got %h want ffffffff", rd); end
        reg_read(A_MTIME, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_mtime: got %h want 0", rd); end
        reg_read(A_CTRL, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", rd); end
    endtask

    task automatic test_edge_ack();
        event_i[20] = 1'b1;
        tick();
        n_vec++; if (irq_o !== 32'h0010_0000) begin n_err++; $display("FAIL edge_capture: got %h want 00100000", irq_o); end
        tick();
        tick();
        n_vec++; if (irq_o[20] !== 1'b1) begin n_err++; $display("FAIL edge_hold: got %b want 1", irq_o[20]); end
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd20;
        tick();
        irq_ack_i = 1'b0;
        n_vec++; if (irq_o[20] !== 1'b0) begin n_err++; $display("FAIL ack_clear: got %b want 0", irq_o[20]); end
        tick();
        tick();
        tick();
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL level_single_capture: got %h want 0", irq_o); end
        event_i[20] = 1'b0;
        tick();
    endtask

    task automatic test_set_wins();
        event_i[16] = 1'b1;
        tick();
        event_i[16] = 1'b0;
        n_vec++; if (irq_o[16] !== 1'b1) begin n_err++; $display("FAIL pend16_setup: got %b want 1", irq_o[16]); end
        tick();
        event_i[16] = 1'b1;
        irq_ack_i   = 1'b1;
        irq_id_i    = 5'd16;
        tick();
        irq_ack_i   = 1'b0;
        n_vec++; if (irq_o[16] !== 1'b1) begin n_err++; $display("FAIL rise_beats_ack: got %b want 1", irq_o[16]); end
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        n_vec++; if (irq_o[16] !== 1'b0) begin n_err++; $display("FAIL ack16_clear: got %b want 0", irq_o[16]); end
        event_i[16] = 1'b0;
        tick();
        event_i[16] = 1'b1;
        reg_write(A_CLR, 32'h0001_0000);
        n_vec++; if (irq_o[16] !== 1'b1) begin n_err++; $display("FAIL rise_beats_clr: got %b want 1", irq_o[16]); end
        event_i[16] = 1'b0;
        reg_write(A_CLR, 32'h0001_0000);
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL clr_write16: got %h want 0", irq_o); end
    endtask

    task automatic test_msi();
        reg_write(A_SET, 32'h0000_0008);
        n_vec++; if (irq_o !== 32'h0000_0008) begin n_err++; $display("FAIL msi_set: got %h want 00000008", irq_o); end
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd3;
        tick();
        irq_ack_i = 1'b0;
        n_vec++; if (irq_o[3] !== 1'b1) begin n_err++; $display("FAIL msi_ack_ignored: got %b want 1", irq_o[3]); end
        reg_write(A_CLR, 32'h0000_0008);
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL msi_clr: got %h want 0", irq_o); end
        reg_write(A_SET, 32'hFFFF_FFFF);
        n_vec++; if (irq_o !== 32'hFFFF_0008) begin n_err++; $display("FAIL set_all_masked: got %h want ffff0008", irq_o); end
        reg_read(A_PEND, rd);
        n_vec++; if (rd !== 32'hFFFF_0008) begin n_err++; $display("FAIL pend_read_set: got %h want ffff0008", rd); end
        reg_write(A_CLR, 32'hFFFF_FFFF);
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL clr_all: got %h want 0", irq_o); end
    endtask

    task automatic test_timer();
        reg_write(A_MTIMECMP, 32'd10);
        reg_write(A_MTIME, 32'd0);
        reg_write(A_CTRL, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        n_vec++; if (irq_o[7] !== 1'b0) begin n_err++; $display("FAIL mti_early: got %b want 0", irq_o[7]); end
        tick();
        n_vec++; if (irq_o !== 32'h0000_0080) begin n_err++; $display("FAIL mti_rise: got %h want 00000080", irq_o); end
        reg_read(A_MTIME, rd);
        n_vec++; if (rd !== 32'd11) begin n_err++; $display("FAIL mtime_count: got %0d want 11", rd); end
        reg_write(A_MTIMECMP, 32'hFFFF_FFFF);
        n_vec++; if (irq_o[7] !== 1'b1) begin n_err++; $display("FAIL mti_cmp_lag: got %b want 1", irq_o[7]); end
        tick();
        n_vec++; if (irq_o[7] !== 1'b0) begin n_err++; $display("FAIL mti_fall: got %b want 0", irq_o[7]); end
        reg_write(A_MTIME, 32'd5);
        reg_read(A_MTIME, rd);
        n_vec++; if (rd !== 32'd5) begin n_err++; $display("FAIL mtime_write_priority: got %0d want 5", rd); end
        reg_write(A_MTIME, 32'hFFFF_FFFE);
        tick();
        tick();
        n_vec++; if (irq_o[7] !== 1'b1) begin n_err++; $display("FAIL mti_at_max: got %b want 1", irq_o[7]); end
        reg_read(A_MTIME, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL mtime_wrap: got %h want 0", rd); end
        n_vec++; if (irq_o[7] !== 1'b0) begin n_err++; $display("FAIL mti_after_wrap: got %b want 0", irq_o[7]); end
        reg_write(A_CTRL, 32'd0);
    endtask

    task automatic test_mask_level();
        event_i = 32'h0000_F477;
        tick();
        tick();
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL mask_unimpl: got %h want 0", irq_o); end
        event_i = 32'h0000_FC77;
        tick();
        n_vec++; if (irq_o !== 32'h0000_0800) begin n_err++; $display("FAIL mei_rise: got %h want 00000800", irq_o); end
        reg_read(A_PEND, rd);
        n_vec++; if (rd !== 32'h0000_0800) begin n_err++; $display("FAIL pend_read_mei: got %h want 00000800", rd); end
        event_i = 32'h0000_F477;
        tick();
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL mei_fall: got %h want 0", irq_o); end
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd11;
        event_i   = 32'h0000_0800;
        tick();
        irq_ack_i = 1'b0;
        tick();
        n_vec++; if (irq_o !== 32'h0000_0800) begin n_err++; $display("FAIL mei_ack_ignored: got %h want 00000800", irq_o); end
        event_i = 32'h0;
        tick();
    endtask

    task automatic test_regport();
        reg_req_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = A_RSV6;
        reg_wdata_i = 32'hFFFF_FFFF;
        #1;
        n_vec++; if (reg_gnt_o !== 1'b1) begin n_err++; $display("FAIL gnt_on_req: got %b want 1", reg_gnt_o); end
        tick();
        reg_we_i   = 1'b0;
        reg_addr_i = A_RSV7;
        n_vec++; if (reg_rvalid_o !== 1'b1 || reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL wr_resp: got v=%b d=%h want v=1 d=0", reg_rvalid_o, reg_rdata_o); end
        tick();
        reg_req_i = 1'b0;
        n_vec++; if (reg_rvalid_o !== 1'b1 || reg_rdata_o !== 32'h0) begin n_err++; $display("FAIL rsv_read: got v=%b d=%h want v=1 d=0", reg_rvalid_o, reg_rdata_o); end
        n_vec++; if (reg_gnt_o !== 1'b0) begin n_err++; $display("FAIL gnt_idle: got %b want 0", reg_gnt_o); end
        tick();
        n_vec++; if (reg_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rvalid_drop: got %b want 0", reg_rvalid_o); end
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL rsv_write_effect: got %h want 0", irq_o); end
        reg_write(A_CTRL, 32'hFFFF_FFFF);
        reg_read(A_CTRL, rd);
        n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL ctrl_readback: got %h want 1", rd); end
        reg_write(A_CTRL, 32'h0);
        reg_write(A_SET, 32'h0001_0000);
        reg_read(A_SET, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL set_reads_zero: got %h want 0", rd); end
        reg_read(A_CLR, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL clr_reads_zero: got %h want 0", rd); end
        reg_write(A_CLR, 32'h0001_0000);
    endtask

    task automatic test_reset_mid();
        reg_write(A_SET, 32'hFFFF_0000);
        reg_write(A_MTIMECMP, 32'h0);
        reg_write(A_CTRL, 32'h1);
        tick();
        n_vec++; if (irq_o !== 32'hFFFF_0080) begin n_err++; $display("FAIL pre_reset_state: got %h want ffff0080", irq_o); end
        reg_req_i  = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = A_PEND;
        rst_n      = 1'b0;
        tick();
        rst_n      = 1'b1;
        reg_req_i  = 1'b0;
        n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL midreset_irq: got %h want 0", irq_o); end
        n_vec++; if (reg_rvalid_o !== 1'b0) begin n_err++; $display("FAIL midreset_rvalid: got %b want 0", reg_rvalid_o); end
        reg_read(A_MTIMECMP, rd);
        n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL midreset_mtimecmp: got %h want ffffffff", rd); end
        reg_read(A_CTRL, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL midreset_ctrl: got %h want 0", rd); end
    endtask

    initial begin
        rst_n       = 1'b0;
        event_i     = '0;
        irq_ack_i   = 1'b0;
        irq_id_i    = '0;
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;

        test_reset();
        test_edge_ack();
        test_set_wins();
        test_msi();
        test_timer();
        test_mask_level();
        test_regport();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
